// File: rtl/pipeline_pkg.sv
// Shared pipeline types and encodings for the RV32I ID/EX boundary.
package pipeline_pkg;

    localparam int REG_IDX_W  = 5;
    localparam int ALU_CTRL_W = 3;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    typedef struct packed {
        logic                  reg_write;
        logic [1:0]            result_src;
        logic                  mem_write;
        logic                  jump;
        logic                  branch;
        logic [ALU_CTRL_W-1:0] alu_ctrl;
        logic                  alu_src;
    } id_ex_ctrl_t;

    // A bubble must not write registers, write memory or redirect the PC.
    localparam id_ex_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/id_ex_register_sat_counter.sv
// Saturating up-counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with flush > stall > load priority.
// Optional stall/flush performance counters are built when ID_EX_PERF_CNT_EN is defined.
module id_ex_register
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 id_valid_i,
    input  logic [DATA_W-1:0]    id_pc_i,
    input  logic [DATA_W-1:0]    id_pc_plus4_i,
    input  logic [DATA_W-1:0]    id_rd1_i,
    input  logic [DATA_W-1:0]    id_rd2_i,
    input  logic [DATA_W-1:0]    id_imm_ext_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    input  logic [REG_IDX_W-1:0] id_rd_i,
    input  id_ex_ctrl_t          id_ctrl_i,
    output logic                 ex_valid_o,
    output logic [DATA_W-1:0]    ex_pc_o,
    output logic [DATA_W-1:0]    ex_pc_plus4_o,
    output logic [DATA_W-1:0]    ex_rd1_o,
    output logic [DATA_W-1:0]    ex_rd2_o,
    output logic [DATA_W-1:0]    ex_imm_ext_o,
    output logic [REG_IDX_W-1:0] ex_rs1_o,
    output logic [REG_IDX_W-1:0] ex_rs2_o,
    output logic [REG_IDX_W-1:0] ex_rd_o,
    output id_ex_ctrl_t          ex_ctrl_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    logic                 valid_q, valid_d;
    logic [DATA_W-1:0]    pc_q, pc_d, pc4_q, pc4_d;
    logic [DATA_W-1:0]    rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
    logic [REG_IDX_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    id_ex_ctrl_t          ctrl_q, ctrl_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        if (flush_i) begin
            valid_d = 1'b0;
            pc_d    = '0;
            pc4_d   = '0;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            ctrl_d  = BUBBLE_CTRL;
        end else if (!stall_i) begin
            valid_d = id_valid_i;
            pc_d    = id_pc_i;
            pc4_d   = id_pc_plus4_i;
            rd1_d   = id_rd1_i;
            rd2_d   = id_rd2_i;
            imm_d   = id_imm_ext_i;
            rs1_d   = id_rs1_i;
            rs2_d   = id_rs2_i;
            rd_d    = id_rd_i;
            // Data still flows for an invalid slot; only its side effects are killed.
            ctrl_d  = id_valid_i ? id_ctrl_i : BUBBLE_CTRL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctrl_q  <= BUBBLE_CTRL;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ex_valid_o    = valid_q;
    assign ex_pc_o       = pc_q;
    assign ex_pc_plus4_o = pc4_q;
    assign ex_rd1_o      = rd1_q;
    assign ex_rd2_o      = rd2_q;
    assign ex_imm_ext_o  = imm_q;
    assign ex_rs1_o      = rs1_q;
    assign ex_rs2_o      = rs2_q;
    assign ex_rd_o       = rd_q;
    assign ex_ctrl_o     = ctrl_q;

`ifdef ID_EX_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_i & ~flush_i),
        .count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_i),
        .count (flush_cnt_o)
    );
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: directed table, stall/reset/saturation sequences, random run.
module tb_id_ex_register;
    import pipeline_pkg::*;

    localparam int DW   = 32;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic            stall_i, flush_i, id_valid_i;
    logic [DW-1:0]   id_pc_i, id_pc_plus4_i, id_rd1_i, id_rd2_i, id_imm_ext_i;
    logic [4:0]      id_rs1_i, id_rs2_i, id_rd_i;
    id_ex_ctrl_t     id_ctrl_i;
    logic            ex_valid_o;
    logic [DW-1:0]   ex_pc_o, ex_pc_plus4_o, ex_rd1_o, ex_rd2_o, ex_imm_ext_o;
    logic [4:0]      ex_rs1_o, ex_rs2_o, ex_rd_o;
    id_ex_ctrl_t     ex_ctrl_o;
    logic [CW-1:0]   stall_cnt_o, flush_cnt_o;

    always #5 clk = ~clk;

    id_ex_register #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_pc_plus4_i(id_pc_plus4_i),
        .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_ext_i(id_imm_ext_i),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_ctrl_i(id_ctrl_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_pc_plus4_o(ex_pc_plus4_o),
        .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_ext_o(ex_imm_ext_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .ex_ctrl_o(ex_ctrl_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the EX-side view of the pipeline, as plain variables.
    logic        m_valid;
    logic [31:0] m_pc, m_pc4, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    id_ex_ctrl_t m_ctrl;
    int          m_scnt, m_fcnt;

    function automatic id_ex_ctrl_t mkc(input logic rw, input logic [1:0] rs, input logic mw,
                                        input logic j, input logic b, input logic [2:0] alu,
                                        input logic src);
        id_ex_ctrl_t c;
        c.reg_write = rw; c.result_src = rs; c.mem_write = mw; c.jump = j;
        c.branch = b; c.alu_ctrl = alu; c.alu_src = src;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = '0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_edge();
`ifdef ID_EX_PERF_CNT_EN
        if (flush_i) m_fcnt = (m_fcnt < CMAX) ? m_fcnt + 1 : CMAX;
        else if (stall_i) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
`endif
        if (flush_i) begin
            m_valid = 0; m_pc = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = '0;
        end else if (!stall_i) begin
            m_valid = id_valid_i; m_pc = id_pc_i; m_pc4 = id_pc_plus4_i;
            m_rd1 = id_rd1_i; m_rd2 = id_rd2_i; m_imm = id_imm_ext_i;
            m_rs1 = id_rs1_i; m_rs2 = id_rs2_i; m_rd = id_rd_i;
            m_ctrl = id_valid_i ? id_ctrl_i : '0;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".valid"}, {31'b0, ex_valid_o}, {31'b0, m_valid});
        chk({tag, ".pc"}, ex_pc_o, m_pc);
        chk({tag, ".pc4"}, ex_pc_plus4_o, m_pc4);
        chk({tag, ".rd1"}, ex_rd1_o, m_rd1);
        chk({tag, ".rd2"}, ex_rd2_o, m_rd2);
        chk({tag, ".imm"}, ex_imm_ext_o, m_imm);
        chk({tag, ".regs"}, {17'b0, ex_rs1_o, ex_rs2_o, ex_rd_o}, {17'b0, m_rs1, m_rs2, m_rd});
        chk({tag, ".ctrl"}, {22'b0, ex_ctrl_o}, {22'b0, m_ctrl});
        chk({tag, ".stall_cnt"}, {28'b0, stall_cnt_o}, m_scnt);
        chk({tag, ".flush_cnt"}, {28'b0, flush_cnt_o}, m_fcnt);
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic rand_inputs();
        id_valid_i    = 1'($urandom);
        id_pc_i       = $urandom;
        id_pc_plus4_i = $urandom;
        id_rd1_i      = $urandom;
        id_rd2_i      = $urandom;
        id_imm_ext_i  = $urandom;
        id_rs1_i      = 5'($urandom);
        id_rs2_i      = 5'($urandom);
        id_rd_i       = 5'($urandom);
        id_ctrl_i     = id_ex_ctrl_t'($urandom);
    endtask

    typedef struct {
        logic        flush, stall, valid;
        logic [31:0] rd1, imm;
        logic [4:0]  rd;
        id_ex_ctrl_t ctrl;
        logic        exp_valid;
        logic [31:0] exp_rd1, exp_imm;
        logic [4:0]  exp_rd;
        id_ex_ctrl_t exp_ctrl;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [31:0] snap_imm, snap_rd1;
        int          scnt_before;

        tbl[0] = '{0, 0, 1, 32'h11, 32'hFFFFF800, 5'd5, mkc(1, RESULT_SRC_ALU, 0, 0, 0, 3'd2, 1),
                   1, 32'h11, 32'hFFFFF800, 5'd5, mkc(1, RESULT_SRC_ALU, 0, 0, 0, 3'd2, 1)};
        tbl[1] = '{0, 0, 0, 32'h1234, 32'h4, 5'd7, mkc(0, RESULT_SRC_ALU, 1, 0, 0, 3'd0, 1),
                   0, 32'h1234, 32'h4, 5'd7, '0};
        tbl[2] = '{0, 1, 1, 32'hDEAD, 32'h99, 5'd9, mkc(1, RESULT_SRC_MEM, 0, 0, 0, 3'd1, 1),
                   0, 32'h1234, 32'h4, 5'd7, '0};
        tbl[3] = '{1, 1, 1, 32'hBEEF, 32'h77, 5'd3, mkc(1, RESULT_SRC_MEM, 1, 1, 1, 3'd7, 1),
                   0, 32'h0, 32'h0, 5'd0, '0};
        tbl[4] = '{0, 0, 1, 32'hCAFE, 32'h7FF, 5'd31, mkc(1, RESULT_SRC_PC4, 0, 1, 0, 3'd0, 0),
                   1, 32'hCAFE, 32'h7FF, 5'd31, mkc(1, RESULT_SRC_PC4, 0, 1, 0, 3'd0, 0)};

        reset = 1; stall_i = 0; flush_i = 0;
        rand_inputs();
        model_reset();
        #2;
        compare_all("reset_init");
        @(posedge clk); #1;
        compare_all("reset_held");
        #3 reset = 0;

        for (int i = 0; i < 5; i++) begin
            rand_inputs();
            flush_i = tbl[i].flush; stall_i = tbl[i].stall; id_valid_i = tbl[i].valid;
            id_rd1_i = tbl[i].rd1; id_imm_ext_i = tbl[i].imm; id_rd_i = tbl[i].rd;
            id_ctrl_i = tbl[i].ctrl;
            step($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_valid", i), {31'b0, ex_valid_o}, {31'b0, tbl[i].exp_valid});
            chk($sformatf("tbl%0d.exp_rd1", i), ex_rd1_o, tbl[i].exp_rd1);
            chk($sformatf("tbl%0d.exp_imm", i), ex_imm_ext_o, tbl[i].exp_imm);
            chk($sformatf("tbl%0d.exp_rd", i), {27'b0, ex_rd_o}, {27'b0, tbl[i].exp_rd});
            chk($sformatf("tbl%0d.exp_ctrl", i), {22'b0, ex_ctrl_o}, {22'b0, tbl[i].exp_ctrl});
        end

        // Three-edge stall with changing inputs: outputs frozen at pre-stall values.
        snap_imm = ex_imm_ext_o;
        snap_rd1 = ex_rd1_o;
        scnt_before = stall_cnt_o;
        flush_i = 0; stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step("stall3");
            chk("stall3.imm_frozen", ex_imm_ext_o, snap_imm);
            chk("stall3.rd1_frozen", ex_rd1_o, snap_rd1);
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("stall3.cnt", {28'b0, stall_cnt_o}, scnt_before + 3);
`else
        chk("stall3.cnt", {28'b0, stall_cnt_o}, 32'd0);
`endif
        stall_i = 0;
        rand_inputs();
        step("stall3_release");

        // Asynchronous reset mid-cycle while a valid reg_write instruction sits in EX.
        id_valid_i = 1; id_ctrl_i = mkc(1, RESULT_SRC_ALU, 0, 0, 0, 3'd0, 0);
        step("pre_reset");
        #3 reset = 1;
        model_reset();
        #1;
        compare_all("async_reset");
        stall_i = 1; flush_i = 1;
        @(posedge clk); #1;
        compare_all("reset_wins");
        #3 reset = 0;
        stall_i = 0; flush_i = 0;

        // Stall counter saturation (CNT_W=4).
        stall_i = 1;
        for (int i = 0; i < 20; i++) begin
            rand_inputs();
            step("sat");
        end
`ifdef ID_EX_PERF_CNT_EN
        chk("sat.stall_cnt", {28'b0, stall_cnt_o}, 32'd15);
`else
        chk("sat.stall_cnt", {28'b0, stall_cnt_o}, 32'd0);
`endif
        stall_i = 0;

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            flush_i = ($urandom_range(7) == 0);
            stall_i = ($urandom_range(3) == 0);
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
